// File: rtl/key_pkg.sv
// Shared types for the push-button front-end: per-channel FSM states and
// the electrical level of a pressed key on the raw pins.
package key_pkg;

   typedef enum logic [1:0] {IDLE, PCHK, PRESSED, RCHK} key_state_t;

   localparam logic KEY_ACTIVE_LVL = 1'b0;

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: two-flop synchroniser, debounce/hold FSM and registered
// level plus single-cycle press, release and long-press pulses.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | key accepted released, waiting for a pressed sample
//   PCHK    | pressed samples seen, counting towards acceptance
//   PRESSED | key accepted pressed, hold timer running until long fires
//   RCHK    | released samples seen while pressed, counting to release
module key_debounce_ch
   import key_pkg::*;
#(
   parameter int DEBOUNCE_CYC = 1_000_000,
   parameter int LONG_CYC     = 50_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic key_in,
   output logic key_level,
   output logic key_press,
   output logic key_release,
   output logic key_long
);

   localparam int DW = $clog2(DEBOUNCE_CYC);
   localparam int HW = $clog2(LONG_CYC);
   localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYC - 1);
   localparam logic [HW-1:0] H_LAST = HW'(LONG_CYC - 1);

   logic          sync_q1, sync_q2;
   logic          s;
   key_state_t    state, state_nxt;
   logic [DW-1:0] dcnt, dcnt_nxt;
   logic [HW-1:0] hcnt, hcnt_nxt;
   logic          long_done, long_done_nxt;
   logic          level_nxt, press_nxt, release_nxt, long_nxt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q1 <= 1'b1;
         sync_q2 <= 1'b1;
      end else begin
         sync_q1 <= key_in;
         sync_q2 <= sync_q1;
      end
   end

   assign s = (sync_q2 == KEY_ACTIVE_LVL);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         dcnt        <= '0;
         hcnt        <= '0;
         long_done   <= 1'b0;
         key_level   <= 1'b0;
         key_press   <= 1'b0;
         key_release <= 1'b0;
         key_long    <= 1'b0;
      end else begin
         state       <= state_nxt;
         dcnt        <= dcnt_nxt;
         hcnt        <= hcnt_nxt;
         long_done   <= long_done_nxt;
         key_level   <= level_nxt;
         key_press   <= press_nxt;
         key_release <= release_nxt;
         key_long    <= long_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      dcnt_nxt      = dcnt;
      hcnt_nxt      = hcnt;
      long_done_nxt = long_done;
      level_nxt     = key_level;
      press_nxt     = 1'b0;
      release_nxt   = 1'b0;
      long_nxt      = 1'b0;
      case (state)
         IDLE: begin
            if (s) begin
               state_nxt = PCHK;
               dcnt_nxt  = DW'(1);
            end
         end
         PCHK: begin
            if (!s) begin
               state_nxt = IDLE;
               dcnt_nxt  = '0;
            end else if (dcnt == D_LAST) begin
               state_nxt     = PRESSED;
               press_nxt     = 1'b1;
               level_nxt     = 1'b1;
               dcnt_nxt      = '0;
               hcnt_nxt      = '0;
               long_done_nxt = 1'b0;
            end else begin
               dcnt_nxt = dcnt + DW'(1);
            end
         end
         PRESSED: begin
            if (!s) begin
               state_nxt = RCHK;
               dcnt_nxt  = DW'(1);
            end else if (!long_done) begin
               // hcnt parks at its last value once the long pulse has fired
               if (hcnt == H_LAST) begin
                  long_nxt      = 1'b1;
                  long_done_nxt = 1'b1;
               end else begin
                  hcnt_nxt = hcnt + HW'(1);
               end
            end
         end
         RCHK: begin
            if (s) begin
               state_nxt = PRESSED;
               dcnt_nxt  = '0;
            end else if (dcnt == D_LAST) begin
               state_nxt   = IDLE;
               release_nxt = 1'b1;
               level_nxt   = 1'b0;
               dcnt_nxt    = '0;
            end else begin
               dcnt_nxt = dcnt + DW'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: rtl/key_event_debounce.sv
// Push-button front-end: NUM_KEYS independent debounced channels producing
// a clean pressed level and single-cycle press/release/long-press events.
module key_event_debounce #(
   parameter int NUM_KEYS     = 2,
   parameter int DEBOUNCE_CYC = 1_000_000,
   parameter int LONG_CYC     = 50_000_000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_KEYS-1:0] key_in,
   output logic [NUM_KEYS-1:0] key_level,
   output logic [NUM_KEYS-1:0] key_press,
   output logic [NUM_KEYS-1:0] key_release,
   output logic [NUM_KEYS-1:0] key_long
);

   for (genvar g = 0; g < NUM_KEYS; g++) begin : g_ch
      key_debounce_ch #(
         .DEBOUNCE_CYC (DEBOUNCE_CYC),
         .LONG_CYC     (LONG_CYC)
      ) u_ch (
         .clk         (clk),
         .rst         (rst),
         .key_in      (key_in[g]),
         .key_level   (key_level[g]),
         .key_press   (key_press[g]),
         .key_release (key_release[g]),
         .key_long    (key_long[g])
      );
   end

endmodule

// File: tb/tb_key_event_debounce.sv
// Bench for key_event_debounce: directed scenarios plus random key activity,
// every cycle compared against a run-length model of the debounce rules.
module tb_key_event_debounce;

   localparam int NK = 2;
   localparam int DC = 4;
   localparam int LC = 20;

   logic          clk = 1'b0;
   logic          rst;
   logic [NK-1:0] key_in;
   logic [NK-1:0] key_level, key_press, key_release, key_long;

   always #5 clk = ~clk;

   key_event_debounce #(
      .NUM_KEYS     (NK),
      .DEBOUNCE_CYC (DC),
      .LONG_CYC     (LC)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .key_in      (key_in),
      .key_level   (key_level),
      .key_press   (key_press),
      .key_release (key_release),
      .key_long    (key_long)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // model: pin pipeline, then counts of consecutive samples that disagree
   // with the accepted level, and counts of hold samples while pressed
   logic m_q0[NK], m_q1[NK];
   int   m_run[NK], m_hold[NK];
   bit   m_lvl[NK], m_done[NK], m_press[NK], m_rel[NK], m_long[NK];

   function automatic void model_reset();
      for (int i = 0; i < NK; i++) begin
         m_q0[i] = 1'b1; m_q1[i] = 1'b1;
         m_run[i] = 0; m_hold[i] = 0;
         m_lvl[i] = 0; m_done[i] = 0;
         m_press[i] = 0; m_rel[i] = 0; m_long[i] = 0;
      end
   endfunction

   function automatic void model_step(input logic [NK-1:0] kin);
      bit s;
      for (int i = 0; i < NK; i++) begin
         s = !m_q1[i];
         m_q1[i] = m_q0[i];
         m_q0[i] = kin[i];
         m_press[i] = 0; m_rel[i] = 0; m_long[i] = 0;
         if (s != m_lvl[i]) begin
            m_run[i]++;
            if (m_run[i] == DC) begin
               m_run[i] = 0;
               m_lvl[i] = s;
               if (s) begin
                  m_press[i] = 1; m_hold[i] = 0; m_done[i] = 0;
               end else begin
                  m_rel[i] = 1;
               end
            end
         end else if (m_run[i] > 0) begin
            m_run[i] = 0;
         end else if (m_lvl[i] && !m_done[i]) begin
            m_hold[i]++;
            if (m_hold[i] == LC) begin
               m_long[i] = 1; m_done[i] = 1;
            end
         end
      end
   endfunction

   int cyc = 0;
   int cnt_press[NK], cnt_rel[NK], cnt_long[NK], t_press[NK], t_long[NK];

   initial begin
      for (int i = 0; i < NK; i++) begin
         cnt_press[i] = 0; cnt_rel[i] = 0; cnt_long[i] = 0;
         t_press[i] = 0; t_long[i] = 0;
      end
      forever begin
         @(posedge clk);
         if (rst) model_reset();
         else model_step(key_in);
         cyc++;
         #1;
         for (int i = 0; i < NK; i++) begin
            chk("level", key_level[i], m_lvl[i]);
            chk("press", key_press[i], m_press[i]);
            chk("release", key_release[i], m_rel[i]);
            chk("long", key_long[i], m_long[i]);
            chk("exclusive", (int'(key_press[i]) + int'(key_release[i]) + int'(key_long[i])) <= 1, 1);
            if (key_press[i]) begin cnt_press[i]++; t_press[i] = cyc; end
            if (key_release[i]) cnt_rel[i]++;
            if (key_long[i]) begin cnt_long[i]++; t_long[i] = cyc; end
         end
      end
   end

   // counts negedges until the selected pulse is seen; -1 on timeout
   task automatic wait_pulse(input int ch, input int kind, input int limit, output int n);
      n = -1;
      for (int k = 1; k <= limit; k++) begin
         @(negedge clk);
         if ((kind == 0 && key_press[ch]) || (kind == 1 && key_release[ch]) ||
             (kind == 2 && key_long[ch])) begin
            n = k;
            break;
         end
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   int lat, p0, r0, l0, p1, r1, l1;
   int rem[NK];

   initial begin
      model_reset();
      rst    = 1'b1;
      key_in = '1;

      // 1: reset with keys released, then quiet
      idle(3);
      chk("rst_level", key_level, 0);
      chk("rst_pulses", {key_press, key_release, key_long}, 0);
      rst = 1'b0;
      p0 = cnt_press[0] + cnt_press[1];
      idle(50);
      chk("quiet_press", cnt_press[0] + cnt_press[1], p0);
      chk("quiet_level", key_level, 0);

      // 2: key 0 press and release latency
      key_in[0] = 1'b0;
      wait_pulse(0, 0, 50, lat);
      chk("press_latency", lat, DC + 2);
      chk("press_level", key_level[0], 1);
      l0 = cnt_long[0];
      idle(3);
      key_in[0] = 1'b1;
      wait_pulse(0, 1, 50, lat);
      chk("release_latency", lat, DC + 2);
      chk("release_level", key_level[0], 0);
      chk("short_no_long", cnt_long[0], l0);

      // 3: key 1 bouncing faster than the debounce window
      idle(10);
      p1 = cnt_press[1];
      for (int r = 0; r < 10; r++) begin
         key_in[1] = 1'b0; idle(3);
         key_in[1] = 1'b1; idle(1);
      end
      idle(10);
      chk("bounce_press", cnt_press[1], p1);
      chk("bounce_level", key_level[1], 0);

      // 4: long hold on key 0
      l0 = cnt_long[0]; r0 = cnt_rel[0];
      key_in[0] = 1'b0;
      wait_pulse(0, 0, 50, lat);
      chk("hold_press_latency", lat, DC + 2);
      wait_pulse(0, 2, 60, lat);
      chk("long_latency", lat, LC);
      idle(40);
      chk("long_once", cnt_long[0] - l0, 1);
      key_in[0] = 1'b1;
      idle(20);
      chk("long_release_once", cnt_rel[0] - r0, 1);

      // 5: both keys together, key 1 glitches released while held
      l0 = cnt_long[0]; l1 = cnt_long[1]; r1 = cnt_rel[1];
      key_in = '0;
      lat = -1;
      for (int k = 1; k <= 50; k++) begin
         @(negedge clk);
         if (key_press != 0) begin lat = k; break; end
      end
      chk("dual_press_vec", key_press, 2'b11);
      chk("dual_press_latency", lat, DC + 2);
      idle(5);
      key_in[1] = 1'b1; idle(2);
      key_in[1] = 1'b0;
      idle(40);
      chk("glitch_no_release", cnt_rel[1], r1);
      chk("dual_long0", cnt_long[0] - l0, 1);
      chk("dual_long1", cnt_long[1] - l1, 1);
      chk("long0_gap", t_long[0] - t_press[0], LC);
      chk("long1_gap_resumed", t_long[1] - t_press[1], LC + 3);
      key_in = '1;
      idle(20);
      chk("dual_released", key_level, 0);

      // 6: reset during press debounce, key still held afterwards
      p0 = cnt_press[0];
      key_in[0] = 1'b0;
      idle(4);
      rst = 1'b1;
      model_reset();
      #1;
      chk("abort_level", key_level, 0);
      idle(2);
      chk("abort_no_press", cnt_press[0], p0);
      rst = 1'b0;
      wait_pulse(0, 0, 50, lat);
      chk("post_reset_latency", lat, DC + 2);
      chk("post_reset_count", cnt_press[0] - p0, 1);
      key_in[0] = 1'b1;
      idle(20);

      // random activity with occasional resets
      for (int i = 0; i < NK; i++) rem[i] = 0;
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         if (rst) rst = 1'b0;
         else if ($urandom_range(0, 499) == 0) begin
            rst = 1'b1;
            model_reset();
         end
         for (int i = 0; i < NK; i++) begin
            if (rem[i] == 0) begin
               key_in[i] = ~key_in[i];
               rem[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 60) : $urandom_range(1, 8);
            end
            rem[i]--;
         end
      end
      rst = 1'b0;
      key_in = '1;
      idle(20);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
